mips_div_unit: RTL
==================

Name: mips_div_unit

Overview:
Iterative 32-bit divider for the MIPS pipeline's DIV/DIVU instructions. It sits between the EX stage and the HI/LO register write path. EX issues operands with a start request and holds the pipeline while the unit is busy. On completion the unit presents {remainder, quotient}; EX forwards these as hi_data/lo_data with a HI/LO write enable.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start_i  input  1  division request; held high by EX until ready_o is seen
annul_i  input  1  cancel in-flight division (branch flush / exception)
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
result_o  output  2*WIDTH  {remainder, quotient}; the high half goes to HI, the low half to LO
ready_o  output  1  result valid
busy_o  output  1  high in BY_ZERO and ON; EX uses it as a stall request

Behaviour:
- Reset (rst=1 at a clock edge): state FREE, counter 0, result_o=0, ready_o=0, busy_o=0. Reset overrides all other inputs, including mid-division.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor=0 -> BY_ZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On this transition:
    - Latch the operands.
    - If signed_div_i=1, latch the two's-complement magnitude of each negative operand.
    - Clear the partial remainder; counter=0.
  - Otherwise stay in FREE.
- BY_ZERO: next cycle -> END with result 0.
- ON, one restoring-division step per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Subtract the divisor from the upper part. If the difference is non-negative, keep it and shift in 1; else shift in 0.
  - Counter increments each step.
  - After step WIDTH (counter reaches WIDTH) -> END. In that transition apply the sign fix if signed:
    - quotient negated when the operand signs differ;
    - remainder negated when the dividend is negative.
  - annul_i=1 in ON -> FREE immediately. The result is discarded and ready_o never asserts.
- END:
  - ready_o=1 and result_o=final value. Both are registered outputs.
  - Stays in END while start_i=1.
  - start_i=0 -> FREE; ready_o=0 and result_o=0 on the same edge.
- Outputs outside END: ready_o=0, result_o=0.
- Latency (non-zero divisor): start accepted at edge N, ready_o high after edge N+WIDTH+1 (33 edges for WIDTH=32).
- Latency (divide-by-zero): ready_o high after edge N+2.
- Operands are sampled only when leaving FREE. Later changes on opdata*_i / signed_div_i have no effect.
- start_i dropping during ON has no effect; only annul_i cancels.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps; no trap).
- Divide by zero: result {0,0}, no exception; MIPS leaves this UNPREDICTABLE, and the team fixes it to 0.
- annul_i in FREE with start_i=1: request is not accepted; state stays FREE.
- annul_i in BY_ZERO: -> FREE. annul_i in END: ignored.
- A new request is accepted only after returning to FREE; no back-to-back issue from END.

Test Plan:
- DIVU 100 / 7, start held -> ready_o high exactly 33 cycles after acceptance; result_o = {0x00000002, 0x0000000E}; drop start -> ready_o=0, result_o=0 next edge.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- DIVU 5 / 0 -> busy_o for 1 cycle, ready_o 2 cycles after acceptance, result_o = 0.
- Annul at iteration 10 -> FREE on the next edge, ready_o stays 0, busy_o=0.
- A following request (100 / 7) completes correctly.
- Reset asserted at iteration 20 -> all outputs 0 after that edge.
- Operand inputs toggled during ON -> result unchanged.
- Random signed/unsigned pairs vs a reference model: 1000 cases, including divisor=1, dividend=0, and |divisor| > |dividend|.

Source files
------------

// File: rtl/mips_div_unit.sv
`default_nettype none
// ============================================================================
// mips_div_unit : iterative restoring divider serving MIPS DIV/DIVU  (rev 1.0)
// ============================================================================
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic             neg_quo;
  logic             neg_rem;

  logic             accept;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  assign accept  = start_i && !annul_i;
  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The partial remainder is always below the divisor, so the difference
  // fits in WIDTH bits whenever the trial subtraction succeeds.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, dsr});
    diff     = shifted[WIDTH-1:0] - dsr;
    step_rem = fits ? diff : shifted[WIDTH-1:0];
    step_quo = {quo[WIDTH-2:0], fits};
    fix_quo  = neg_quo ? -step_quo : step_quo;
    fix_rem  = neg_rem ? -step_rem : step_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    case (state)
      FREE: begin
        if (accept) state_next = (opdata2_i == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: begin
        busy_o     = 1'b1;
        state_next = annul_i ? FREE : END;
      end
      ON: begin
        busy_o = 1'b1;
        if (annul_i)                 state_next = FREE;
        else if (count == LAST_STEP) state_next = END;
      end
      END: begin
        if (!start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o  <= 1'b0;
      result_o <= '0;
      case (state)
        FREE: begin
          if (accept && opdata2_i != '0) begin
            quo     <= op1_abs;
            dsr     <= op2_abs;
            rem     <= '0;
            count   <= '0;
            neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        BY_ZERO: begin
          quo <= '0;
          rem <= '0;
        end
        ON: begin
          if (!annul_i) begin
            count <= count + 1'b1;
            // The final step folds in the sign correction on its way to END.
            if (count == LAST_STEP) begin
              quo <= fix_quo;
              rem <= fix_rem;
            end else begin
              quo <= step_quo;
              rem <= step_rem;
            end
          end
        end
        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {rem, quo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
